// File: rtl/layer_store_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : layer_store_bank_if
// Brief    : Capture/swap/stream bus for the ping-pong layer result store.
// Revision : 1.0 - initial release
// ============================================================================
interface layer_store_bank_if #(
  parameter int NUM_CH = 10,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
);
  logic [NUM_CH*DATA_W-1:0] mac_flat;
  logic                     ld_val;
  logic                     swap;
  logic                     rd_start;
  logic                     rd_ready;
  logic                     err_clr;
  logic                     rd_valid;
  logic [DATA_W-1:0]        rd_data;
  logic [IDX_W-1:0]         rd_idx;
  logic                     rd_last;
  logic                     rd_avail;
  logic                     swap_err;

  modport master (
    output mac_flat, ld_val, swap, rd_start, rd_ready, err_clr,
    input  rd_valid, rd_data, rd_idx, rd_last, rd_avail, swap_err
  );

  modport slave (
    input  mac_flat, ld_val, swap, rd_start, rd_ready, err_clr,
    output rd_valid, rd_data, rd_idx, rd_last, rd_avail, swap_err
  );
endinterface
`default_nettype wire

// File: rtl/layer_store_bank.sv
`default_nettype none
// ============================================================================
// Module   : layer_store_bank
// Brief    : Double-buffered store of one layer's MAC results with serial
//            valid/ready read-out and optional ReLU clamp on capture.
// Revision : 1.0 - initial release
// ============================================================================
module layer_store_bank #(
  parameter int NUM_CH  = 10,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = 4,
  parameter bit RELU_EN = 1'b1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  layer_store_bank_if.slave  bus
);

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              r_wsel;
  logic              r_avail;
  logic              r_err;

  logic [DATA_W-1:0] r_bank0 [NUM_CH];
  logic [DATA_W-1:0] r_bank1 [NUM_CH];
  logic [DATA_W-1:0] w_cap   [NUM_CH];
  logic [DATA_W-1:0] w_rd_word;

  logic              w_swap_ok;
  logic              w_swap_rej;
  logic              w_start;
  logic              w_xfer;
  logic              w_xfer_last;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [DATA_W-1:0] w_raw;
      assign w_raw = bus.mac_flat[k*DATA_W +: DATA_W];
      if (RELU_EN) begin : g_relu
        assign w_cap[k] = w_raw[DATA_W-1] ? '0 : w_raw;
      end else begin : g_pass
        assign w_cap[k] = w_raw;
      end
    end
  endgenerate

  // Capture always targets the write bank selected before any same-edge swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_bank0[k] <= '0;
        r_bank1[k] <= '0;
      end
    end else if (bus.ld_val) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (r_wsel) begin
          r_bank1[k] <= w_cap[k];
        end else begin
          r_bank0[k] <= w_cap[k];
        end
      end
    end
  end

  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_rd_word = r_wsel ? r_bank0[k] : r_bank1[k];
      end
    end
  end

  assign w_swap_ok   = (r_state == S_IDLE) && bus.swap;
  assign w_swap_rej  = (r_state == S_STREAM) && bus.swap;
  assign w_start     = (r_state == S_IDLE) && bus.rd_start && r_avail && !bus.swap;
  assign w_xfer      = (r_state == S_STREAM) && bus.rd_ready;
  assign w_xfer_last = w_xfer && (r_idx == c_LAST_IDX);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_STREAM;
          w_idx_nxt   = '0;
        end
      end
      S_STREAM: begin
        if (w_xfer_last) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else if (w_xfer) begin
          w_idx_nxt   = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wsel  <= 1'b0;
      r_avail <= 1'b0;
    end else begin
      if (w_swap_ok) begin
        r_wsel  <= ~r_wsel;
        r_avail <= 1'b1;
      end else if (w_xfer_last) begin
        r_avail <= 1'b0;
      end
    end
  end

  // A rejection in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_swap_rej) begin
      r_err <= 1'b1;
    end else if (bus.err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign bus.rd_valid = (r_state == S_STREAM);
  assign bus.rd_data  = (r_state == S_STREAM) ? w_rd_word : '0;
  assign bus.rd_idx   = r_idx;
  assign bus.rd_last  = (r_state == S_STREAM) && (r_idx == c_LAST_IDX);
  assign bus.rd_avail = r_avail;
  assign bus.swap_err = r_err;

endmodule
`default_nettype wire

// File: doc/layer_store_bank.md
Name: layer_store_bank

Overview:
Parametrised, double-buffered (ping-pong) store for one layer's MAC results. A parallel snapshot of all NUM_CH MAC outputs is captured into the write bank. A swap publishes that bank to the read side. The read side streams the channels out serially over a valid/ready handshake while the next layer's results are captured into the other bank. Optional ReLU clamp on capture.

Parameters:
NUM_CH, 10, number of MAC channels stored per bank (>=2)
DATA_W, 8, width of one channel value in bits (signed two's complement)
IDX_W, 4, index width; must satisfy 2**IDX_W >= NUM_CH
RELU_EN, 1, 1 = negative values are stored as 0; 0 = stored unchanged

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mac_flat  in  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
ld_val  in  1  capture strobe: all channels written into the write bank this edge
swap  in  1  publish the write bank to the read side
rd_start  in  1  request to begin streaming the read bank
rd_ready  in  1  downstream accepts rd_data this cycle
rd_valid  out  1  rd_data/rd_idx valid
rd_data  out  DATA_W  current channel value from the read bank
rd_idx  out  IDX_W  channel index of rd_data
rd_last  out  1  high with rd_valid when rd_idx == NUM_CH-1
rd_avail  out  1  read bank holds published, not yet streamed data
swap_err  out  1  sticky: a swap was rejected
err_clr  in  1  synchronous clear of swap_err

Behaviour:
- Reset (async, rst_n=0):
  - both banks all-zero; wsel=0 (bank 0 writable, bank 1 readable)
  - state IDLE; rd_valid=0, rd_data=0, rd_idx=0, rd_last=0, rd_avail=0, swap_err=0
  - Reset mid-stream aborts immediately; no further words are output.
- Capture: on a rising edge with ld_val=1, bank[wsel][k] <= f(mac ch k) for all k.
  - f(x) = 0 if RELU_EN and x[DATA_W-1]=1; otherwise x.
  - Repeated ld_val overwrites. Capture is allowed in any state and never touches the read bank.
- Swap accepted when state==IDLE and swap=1 on an edge:
  - wsel toggles; rd_avail <= 1.
  - ld_val in the same edge writes the old write bank first, so that data is what gets published.
  - A swap while rd_avail=1 and IDLE is accepted and discards the unstreamed data, with no error.
- Swap rejected when state==STREAM: wsel unchanged, swap_err <= 1. It stays 1 until err_clr=1 or reset; a rejection in the same cycle as err_clr wins, leaving swap_err=1.
- FSM IDLE -> STREAM:
  - Taken on an edge with rd_start=1 and rd_avail=1; rd_idx <= 0.
  - rd_start with rd_avail=0 is ignored.
  - rd_start together with swap in IDLE: the swap is taken and streaming starts on the next rd_start.
- STREAM:
  - rd_valid=1; rd_data = bank[!wsel][rd_idx] (read mux from registered index); rd_last = (rd_idx==NUM_CH-1).
  - First word is valid in the cycle after the accepting edge (latency 1).
  - Handshake: a transfer occurs on an edge with rd_valid & rd_ready. rd_idx then increments.
  - rd_data/rd_idx hold stable while rd_ready=0.
  - Transfer with rd_last=1: state -> IDLE, rd_avail <= 0, rd_idx <= 0, rd_valid drops the next cycle.
- Throughput: one word per cycle with rd_ready held high. A full stream takes NUM_CH cycles after the start latency.
- rd_start while in STREAM is ignored.
- Outputs in IDLE: rd_valid=0, rd_last=0, rd_data=0.

Test Plan:
- Reset, mac ch0=10, ch2=2, ch4=5, ch7=12, ch9=13 (others 0); ld_val, swap, rd_start, rd_ready=1 -> words idx0..9 = 10,0,2,0,5,0,0,12,0,13 on consecutive cycles; rd_last only at idx9; rd_avail falls after idx9.
- Ping-pong:
  - During the above stream, ld_val with ch0=77, ch2=72, ch4=75, ch7=82, ch9=83 -> the stream still outputs the first set.
  - After IDLE, swap+rd_start -> 77,0,72,0,75,0,0,82,0,83.
- RELU_EN=1, ch3=8'hF6 (-10), ch5=8'h7F -> idx3 reads 0, idx5 reads 127. Same test with RELU_EN=0 -> idx3 reads 8'hF6.
- Backpressure: rd_ready toggles 1,0,0,1,... -> no word lost or duplicated, rd_data stable during stalls, 10 transfers total.
- Swap during STREAM -> swap_err=1, stream data unchanged, wsel unchanged. err_clr -> swap_err=0. ld_val+swap in the same edge in IDLE -> the new values are read.
- rst_n pulsed low at idx4 of a stream -> rd_valid=0 immediately, rd_avail=0. A subsequent stream after ld_val/swap reads the new data from idx0.
